// File: rtl/qa_pkg.sv
// Shared definitions for the QA receive packer: FSM state encoding, the
// packet-counter width and a constant-foldable ceil(log2) helper.
package qa_pkg;

  typedef enum logic {
    QA_IDLE = 1'b0,
    QA_SEND = 1'b1
  } qa_state_e;

  localparam int PKT_CNT_W = 16;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/qa_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Writes into a full FIFO and
// reads from an empty FIFO are ignored; DEPTH must be a power of two >= 2.
module qa_sync_fifo
  import qa_pkg::*;
#(
  parameter int WDTH  = 32,
  parameter int DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic [WDTH-1:0]       i_wr_data,
  input  logic                  i_rd_en,
  output logic [WDTH-1:0]       o_rd_data,
  output logic [clog2(DEPTH):0] o_fill,
  output logic                  o_full
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FILL_DEPTH = (AW + 1)'(DEPTH);

  logic [WDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_fill;
  logic            w_wr;
  logic            w_rd;

  assign o_full    = (r_fill == FILL_DEPTH);
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && (r_fill != '0);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_fill    = r_fill;

  // Storage is data only and is never reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: rtl/qa_rx_packer.sv
// Packs a strobed, non-stallable sample stream into fixed-length ready/valid
// packets; samples that arrive while the buffer is full are dropped and flagged.
module qa_rx_packer
  import qa_pkg::*;
#(
  parameter int WDTH    = 32,
  parameter int DEPTH   = 64,
  parameter int PKT_LEN = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WDTH-1:0]      in_data,
  input  logic                 in_nd,
  output logic [WDTH-1:0]      out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 overflow,
  output logic [PKT_CNT_W-1:0] pkt_count
);

  localparam int FILL_W = clog2(DEPTH) + 1;
  localparam int BEAT_W = (clog2(PKT_LEN) < 1) ? 1 : clog2(PKT_LEN);
  localparam logic [FILL_W-1:0] PKT_LEN_F = FILL_W'(PKT_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  qa_state_e            r_state;
  qa_state_e            w_state_nxt;
  logic [BEAT_W-1:0]    r_beat;
  logic [PKT_CNT_W-1:0] r_pkt_count;
  logic                 r_overflow;
  logic [FILL_W-1:0]    w_fill;
  logic                 w_full;
  logic [WDTH-1:0]      w_head;
  logic                 w_valid;
  logic                 w_last;
  logic                 w_xfer;

  assign w_xfer = w_valid && out_ready;

  qa_sync_fifo #(
    .WDTH  (WDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (in_nd),
    .i_wr_data (in_data),
    .i_rd_en   (w_xfer),
    .o_rd_data (w_head),
    .o_fill    (w_fill),
    .o_full    (w_full)
  );

  // A packet only starts once all of it is buffered, so valid never drops mid-packet.
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      QA_IDLE: begin
        if (w_fill >= PKT_LEN_F) begin
          w_state_nxt = QA_SEND;
        end
      end
      QA_SEND: begin
        w_valid = 1'b1;
        w_last  = (r_beat == LAST_BEAT);
        if (out_ready && w_last) begin
          w_state_nxt = QA_IDLE;
        end
      end
      default: w_state_nxt = QA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= QA_IDLE;
      r_beat      <= '0;
      r_pkt_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_beat <= w_last ? '0 : r_beat + 1'b1;
      end
      if (w_xfer && w_last) begin
        r_pkt_count <= r_pkt_count + 1'b1;
      end
      // The drop decision uses registered full, so a same-cycle read does not save the sample.
      if (in_nd && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_data  = w_head;
  assign out_valid = w_valid;
  assign out_last  = w_last;
  assign overflow  = r_overflow;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_qa_rx_packer.sv
// Directed and randomized bench for qa_rx_packer (DEPTH=8, PKT_LEN=4) against a
// queue-based reference model of the buffered packet stream.
module tb_qa_rx_packer;

  localparam int WDTH    = 32;
  localparam int DEPTH   = 8;
  localparam int PKT_LEN = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [WDTH-1:0] in_data = '0;
  logic            in_nd = 1'b0;
  logic [WDTH-1:0] out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_last;
  logic            overflow;
  logic [15:0]     pkt_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] q[$];
  bit          m_valid;
  int          m_beat;
  int          m_pkts;
  bit          m_ovf;
  int          n_out;

  qa_rx_packer #(
    .WDTH    (WDTH),
    .DEPTH   (DEPTH),
    .PKT_LEN (PKT_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_nd     (in_nd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_nd = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    m_valid = 0;
    m_beat = 0;
    m_pkts = 0;
    m_ovf = 0;
    n_out = 0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_fill", 32'(dut.w_fill), 32'd0);
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic cyc(input bit nd, input logic [31:0] d, input bit rdy);
    int sz;
    bit nv;
    in_nd = nd;
    in_data = d;
    out_ready = rdy;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("pkt_count", 32'(pkt_count), 32'(m_pkts));
    chk("fill", 32'(dut.w_fill), 32'(q.size()));
    if (m_valid && q.size() > 0) begin
      chk("out_data", out_data, q[0]);
      chk("out_last", 32'(out_last), 32'(m_beat == PKT_LEN - 1));
    end
    sz = q.size();
    nv = m_valid;
    if (m_valid && rdy) begin
      void'(q.pop_front());
      n_out++;
      if (m_beat == PKT_LEN - 1) begin
        m_beat = 0;
        m_pkts = (m_pkts + 1) % 65536;
        nv = 0;
      end else begin
        m_beat++;
      end
    end else if (!m_valid && sz >= PKT_LEN) begin
      nv = 1;
    end
    if (nd) begin
      if (sz >= DEPTH) m_ovf = 1;
      else q.push_back(d);
    end
    m_valid = nv;
    @(posedge clk); #1;
  endtask

  initial begin
    bit rdy;
    do_reset();

    // Basic packet and start-of-packet latency
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i + 1), 1'b1);
    chk("basic_valid_after_E", 32'(out_valid), 32'd0);
    cyc(1'b0, 32'd0, 1'b1);
    chk("basic_valid_E1", 32'(out_valid), 32'd1);
    chk("basic_first_data", out_data, 32'd1);
    chk("basic_first_last", 32'(out_last), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1);
    chk("basic_last_data", out_data, 32'd4);
    chk("basic_last_flag", 32'(out_last), 32'd1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("basic_bubble", 32'(out_valid), 32'd0);
    chk("basic_pkt_count", 32'(pkt_count), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1);

    // Backpressure with toggling ready
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'(10 + i), (i % 2) == 0);
    for (int k = 0; k < 30; k++) cyc(1'b0, 32'd0, (k % 2) == 0);
    chk("bp_pkt_count", 32'(pkt_count), 32'd2);
    chk("bp_n_out", 32'(n_out), 32'd8);
    chk("bp_overflow", 32'(overflow), 32'd0);

    // Overflow with ready held low
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'(i), 1'b0);
      if (i == 7) begin
        chk("ovf_fill_8th", 32'(dut.w_fill), 32'd8);
        chk("ovf_flag_8th", 32'(overflow), 32'd0);
      end
      if (i == 8) begin
        chk("ovf_fill_9th", 32'(dut.w_fill), 32'd8);
        chk("ovf_flag_9th", 32'(overflow), 32'd1);
      end
    end
    for (int k = 0; k < 20; k++) cyc(1'b0, 32'd0, 1'b1);
    chk("ovf_pkt_count", 32'(pkt_count), 32'd2);
    chk("ovf_n_out", 32'(n_out), 32'd8);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a transfer and a strobe in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'(100 + i), 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    chk("simul_valid", 32'(out_valid), 32'd1);
    cyc(1'b1, 32'd200, 1'b1);
    chk("simul_overflow", 32'(overflow), 32'd1);
    chk("simul_fill", 32'(dut.w_fill), 32'd7);
    for (int k = 0; k < 20; k++) cyc(1'b0, 32'd0, 1'b1);
    chk("simul_pkt_count", 32'(pkt_count), 32'd2);
    chk("simul_n_out", 32'(n_out), 32'd8);

    // Reset mid-packet, then a clean packet
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(30 + i), 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'd0, 1'b1);
    chk("midrst_pre_valid", 32'(out_valid), 32'd1);
    chk("midrst_pre_data", out_data, 32'd32);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(20 + i), 1'b1);
    for (int k = 0; k < 8; k++) cyc(1'b0, 32'd0, 1'b1);
    chk("midrst_pkt_count", 32'(pkt_count), 32'd1);
    chk("midrst_n_out", 32'(n_out), 32'd4);

    // Wrap-around with random ready at one sample per two cycles
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rdy = (q.size() >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc(1'b1, 32'(i), rdy);
      rdy = (q.size() >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc(1'b0, 32'd0, rdy);
    end
    for (int k = 0; k < 40; k++) cyc(1'b0, 32'd0, 1'b1);
    chk("wrap_pkt_count", 32'(pkt_count), 32'd10);
    chk("wrap_n_out", 32'(n_out), 32'd40);
    chk("wrap_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
